// File: rtl/mul_share_pkg.sv
// Shared widths and requester-ID type for the multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int MUL_W   = 16;
    localparam int PROD_W  = 32;
    localparam int MAX_REQ = 8;

    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

endpackage

// File: rtl/mul_tag_fifo.sv
// Synchronous tag FIFO; pointers carry one extra wrap bit to tell full from empty.
module mul_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined 16x16 multiplier among NUM_REQ requesters;
// a tag FIFO routes each product back to the requester that issued it.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*MUL_W-1:0] req_a,
    input  logic [NUM_REQ*MUL_W-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [PROD_W-1:0]        rsp_data,
    output logic [MUL_W-1:0]         mul_a,
    output logic [MUL_W-1:0]         mul_b,
    output logic                     mul_en_in,
    input  logic                     mul_en_out,
    input  logic [PROD_W-1:0]        mul_out,
    output logic                     busy,
    output logic                     err_underflow
);

    req_id_t              last_grant;
    req_id_t              grant_id;
    req_id_t              tag_head;
    logic                 grant_found;
    logic                 accept;
    logic                 tag_full;
    logic                 tag_empty;
    logic                 tag_pop;
    logic [MUL_W-1:0]     sel_a;
    logic [MUL_W-1:0]     sel_b;
    logic [NUM_REQ-1:0]   rsp_sel;

    // Search order starts just after the previous winner and wraps once around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = last_grant;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && req_valid[i] && (i == (32'(last_grant) + off) % NUM_REQ)) begin
                    grant_found = 1'b1;
                    grant_id    = req_id_t'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(grant_id) == i) begin
                req_ready[i] = grant_found & ~tag_full;
                sel_a        = req_a[i*MUL_W +: MUL_W];
                sel_b        = req_b[i*MUL_W +: MUL_W];
            end
        end
    end

    always_comb begin
        rsp_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_sel[i] = (32'(tag_head) == i);
        end
    end

    assign accept  = |req_ready;
    assign tag_pop = mul_en_out & ~tag_empty;
    assign busy    = ~tag_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a         <= '0;
            mul_b         <= '0;
            mul_en_in     <= 1'b0;
            last_grant    <= req_id_t'(NUM_REQ - 1);
            rsp_valid     <= '0;
            rsp_data      <= '0;
            err_underflow <= 1'b0;
        end else begin
            mul_en_in <= accept;
            if (accept) begin
                mul_a      <= sel_a;
                mul_b      <= sel_b;
                last_grant <= grant_id;
            end
            rsp_valid <= tag_pop ? rsp_sel : '0;
            if (tag_pop) begin
                rsp_data <= mul_out;
            end
            if (mul_en_out && tag_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

    mul_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     ($bits(req_id_t))
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (tag_pop),
        .din   (grant_id),
        .full  (tag_full),
        .empty (tag_empty),
        .head  (tag_head)
    );

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: behavioural multiplier plus an in-order operation
// queue model of arbitration and response routing.
module tb_mul_share_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int TAG_DEPTH = 8;
    localparam int MUL_LAT   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*16-1:0] req_a = '0;
    logic [NUM_REQ*16-1:0] req_b = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [31:0]          rsp_data;
    logic [15:0]          mul_a;
    logic [15:0]          mul_b;
    logic                 mul_en_in;
    logic                 mul_en_out;
    logic [31:0]          mul_out;
    logic                 busy;
    logic                 err_underflow;

    int compared = 0;
    int mismatched = 0;

    bit stall = 1'b0;
    bit force_err = 1'b0;
    int release_req = 0;
    int release_done = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_en_in     (mul_en_in),
        .mul_en_out    (mul_en_out),
        .mul_out       (mul_out),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    // Multiplier stand-in: fixed latency, can be stalled or forced to emit.
    logic [31:0] mq_p[$];
    int          mq_t[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_p.delete();
            mq_t.delete();
            mul_en_out <= 1'b0;
            mul_out    <= '0;
        end else begin
            cyc++;
            if (mul_en_in) begin
                mq_p.push_back(32'(mul_a) * 32'(mul_b));
                mq_t.push_back(cyc);
            end
            if (force_err) begin
                mul_en_out <= 1'b1;
                mul_out    <= $urandom;
            end else if ((!stall || release_done < release_req) && mq_p.size() > 0
                         && cyc - mq_t[0] >= MUL_LAT) begin
                if (stall) release_done++;
                mul_en_out <= 1'b1;
                mul_out    <= mq_p.pop_front();
                void'(mq_t.pop_front());
            end else begin
                mul_en_out <= 1'b0;
            end
        end
    end

    // Reference model: operations leave in the order they were issued.
    typedef struct {
        int          id;
        logic [31:0] prod;
    } op_t;

    op_t          exp_q[$];
    int           m_last;
    logic         e_en;
    logic [15:0]  e_a, e_b;
    logic [3:0]   e_rv;
    logic [31:0]  e_rd;
    logic         e_err;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last, input bit full);
        if (full) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c = (last + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = NUM_REQ - 1;
            exp_q.delete();
            e_en = 1'b0; e_a = '0; e_b = '0; e_rv = '0; e_rd = '0; e_err = 1'b0;
        end else begin
            int  g;
            op_t op;
            g = rr_pick(req_valid, m_last, exp_q.size() >= TAG_DEPTH);
            e_rv = '0;
            if (mul_en_out) begin
                if (exp_q.size() > 0) begin
                    op = exp_q.pop_front();
                    e_rv[op.id] = 1'b1;
                    e_rd = op.prod;
                end else begin
                    e_err = 1'b1;
                end
            end
            e_en = (g >= 0);
            if (g >= 0) begin
                e_a = req_a[g*16 +: 16];
                e_b = req_b[g*16 +: 16];
                m_last = g;
                exp_q.push_back('{g, 32'(e_a) * 32'(e_b)});
            end
        end
    end

    always @(posedge clk) begin
        int g2;
        logic [3:0] er;
        #1;
        if (rst_n) begin
            g2 = rr_pick(req_valid, m_last, exp_q.size() >= TAG_DEPTH);
            er = (g2 >= 0) ? 4'(1 << g2) : 4'b0;
            compared += 8;
            if (req_ready !== er) begin
                mismatched++; $display("FAIL req_ready: got %b want %b (t=%0t)", req_ready, er, $time);
            end
            if (mul_en_in !== e_en) begin
                mismatched++; $display("FAIL mul_en_in: got %b want %b (t=%0t)", mul_en_in, e_en, $time);
            end
            if (mul_a !== e_a) begin
                mismatched++; $display("FAIL mul_a: got %0d want %0d (t=%0t)", mul_a, e_a, $time);
            end
            if (mul_b !== e_b) begin
                mismatched++; $display("FAIL mul_b: got %0d want %0d (t=%0t)", mul_b, e_b, $time);
            end
            if (rsp_valid !== e_rv) begin
                mismatched++; $display("FAIL rsp_valid: got %b want %b (t=%0t)", rsp_valid, e_rv, $time);
            end
            if (rsp_data !== e_rd) begin
                mismatched++; $display("FAIL rsp_data: got %0d want %0d (t=%0t)", rsp_data, e_rd, $time);
            end
            if (err_underflow !== e_err) begin
                mismatched++; $display("FAIL err_underflow: got %b want %b (t=%0t)", err_underflow, e_err, $time);
            end
            if (busy !== (exp_q.size() != 0)) begin
                mismatched++; $display("FAIL busy: got %b want %b (t=%0t)", busy, exp_q.size() != 0, $time);
            end
        end
    end

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*16 +: 16]  = a;
        req_b[i*16 +: 16]  = b;
    endtask

    task automatic drain();
        bit done = 1'b0;
        req_valid = '0;
        stall = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            done = !busy && mq_p.size() == 0 && !mul_en_out && rsp_valid == '0;
        end
        compared++;
        if (!done) begin
            mismatched++; $display("FAIL drain: busy=%b still pending after 100 cycles, want idle", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        compared++;
        if ({mul_a, mul_b, mul_en_in, rsp_valid, rsp_data, err_underflow, busy} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: a=%0d b=%0d en=%b rv=%b rd=%0d err=%b busy=%b, want all 0",
                     mul_a, mul_b, mul_en_in, rsp_valid, rsp_data, err_underflow, busy);
        end
        req_valid = 4'b1111;
        #1;
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++; $display("FAIL reset_priority: got %b want 0001", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int en_cnt = 0;
        bit got = 1'b0;
        logic [3:0] rv = '0;
        logic [31:0] rd = '0;
        set_req(0, 16'd10000, 16'd20000);
        #1;
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++; $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        for (int c = 0; c < 30 && !got; c++) begin
            if (c == 0) begin
                compared++;
                if (mul_en_in !== 1'b1) begin
                    mismatched++; $display("FAIL issue_latency: mul_en_in=%b want 1", mul_en_in);
                end
            end
            en_cnt += int'(mul_en_in);
            if (rsp_valid != '0) begin
                got = 1'b1; rv = rsp_valid; rd = rsp_data;
            end else begin
                @(negedge clk);
            end
        end
        compared += 3;
        if (en_cnt != 1) begin
            mismatched++; $display("FAIL single_en_pulse: %0d cycles want 1", en_cnt);
        end
        if (!got || rv !== 4'b0001) begin
            mismatched++; $display("FAIL single_rsp_valid: got %b (seen=%0d) want 0001", rv, got);
        end
        if (rd !== 32'd200000000) begin
            mismatched++; $display("FAIL single_rsp_data: got %0d want 200000000", rd);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int prev = 0;
        logic [3:0] want;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'((i + 1) * 1000), 16'd3);
        for (int c = 0; c < 12; c++) begin
            #1;
            want = 4'(1 << ((prev + 1) % NUM_REQ));
            compared++;
            if (req_ready !== want) begin
                mismatched++; $display("FAIL rr_order cycle %0d: got %b want %b", c, req_ready, want);
            end
            prev = (prev + 1) % NUM_REQ;
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_fifo_full();
        int accepts = 0;
        bit stop = 1'b0;
        stall = 1'b1;
        for (int c = 0; c < 20 && !stop; c++) begin
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'($urandom), 16'($urandom));
            #1;
            if (req_ready != '0) begin
                accepts++;
                @(negedge clk);
            end else begin
                stop = 1'b1;
            end
        end
        compared += 2;
        if (accepts != TAG_DEPTH) begin
            mismatched++; $display("FAIL full_accepts: got %0d want %0d", accepts, TAG_DEPTH);
        end
        if (busy !== 1'b1) begin
            mismatched++; $display("FAIL full_busy: got %b want 1", busy);
        end
        repeat (2) @(negedge clk);
        compared++;
        if (req_ready !== 4'b0000) begin
            mismatched++; $display("FAIL full_hold: got %b want 0000", req_ready);
        end
        release_req++;
        @(negedge clk);
        compared++;
        if (req_ready !== 4'b0000) begin
            mismatched++; $display("FAIL full_pop_same_cycle: got %b want 0000", req_ready);
        end
        @(negedge clk);
        compared++;
        if (req_ready === 4'b0000) begin
            mismatched++; $display("FAIL full_regrant: got %b want nonzero", req_ready);
        end
        @(negedge clk);
        drain();
    endtask

    task automatic test_push_pop();
        int accepts = 0;
        bit stop = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = '0;
            set_req($urandom_range(0, NUM_REQ - 1), 16'($urandom), 16'($urandom));
            @(negedge clk);
        end
        req_valid = '0;
        release_req++;
        @(negedge clk);
        set_req($urandom_range(0, NUM_REQ - 1), 16'($urandom), 16'($urandom));
        @(negedge clk);
        req_valid = '0;
        compared++;
        if (rsp_valid === 4'b0000 || mul_en_in !== 1'b1) begin
            mismatched++; $display("FAIL pushpop_both: rsp_valid=%b mul_en_in=%b want nonzero/1", rsp_valid, mul_en_in);
        end
        for (int c = 0; c < 10 && !stop; c++) begin
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'($urandom), 16'($urandom));
            #1;
            if (req_ready != '0) begin
                accepts++;
                @(negedge clk);
            end else begin
                stop = 1'b1;
            end
        end
        compared++;
        if (accepts != TAG_DEPTH - 5) begin
            mismatched++; $display("FAIL pushpop_count: room for %0d more, want %0d", accepts, TAG_DEPTH - 5);
        end
        drain();
    endtask

    task automatic test_underflow();
        force_err = 1'b1;
        @(negedge clk);
        force_err = 1'b0;
        @(negedge clk);
        compared += 2;
        if (err_underflow !== 1'b1) begin
            mismatched++; $display("FAIL underflow_set: got %b want 1", err_underflow);
        end
        if (rsp_valid !== 4'b0000) begin
            mismatched++; $display("FAIL underflow_no_rsp: got %b want 0000", rsp_valid);
        end
        set_req(2, 16'd300, 16'd7);
        @(negedge clk);
        drain();
        compared++;
        if (err_underflow !== 1'b1) begin
            mismatched++; $display("FAIL underflow_sticky: got %b want 1", err_underflow);
        end
    endtask

    task automatic test_reset_inflight();
        int stale = 0;
        bit got = 1'b0;
        logic [3:0] rv = '0;
        logic [31:0] rd = '0;
        for (int k = 0; k < 3; k++) begin
            req_valid = '0;
            set_req(k, 16'($urandom), 16'($urandom));
            @(negedge clk);
        end
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({mul_a, mul_b, mul_en_in, rsp_valid, rsp_data, err_underflow, busy} !== '0) begin
            mismatched++;
            $display("FAIL reset_midop: a=%0d b=%0d en=%b rv=%b rd=%0d err=%b busy=%b, want all 0",
                     mul_a, mul_b, mul_en_in, rsp_valid, rsp_data, err_underflow, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) stale++;
        end
        compared++;
        if (stale != 0) begin
            mismatched++; $display("FAIL no_stale_rsp: %0d responses want 0", stale);
        end
        set_req(1, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        req_valid = '0;
        for (int c = 0; c < 30 && !got; c++) begin
            if (rsp_valid != '0) begin
                got = 1'b1; rv = rsp_valid; rd = rsp_data;
            end else begin
                @(negedge clk);
            end
        end
        compared += 2;
        if (!got || rv !== 4'b0010) begin
            mismatched++; $display("FAIL max_rsp_valid: got %b (seen=%0d) want 0010", rv, got);
        end
        if (rd !== 32'd4294836225) begin
            mismatched++; $display("FAIL max_rsp_data: got %0d want 4294836225", rd);
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_push_pop();
        test_underflow();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
